// File: rtl/mdu_pkg.sv
// Shared CPU defines: ALU and MDU operation encodings, MDU default
// latencies, and the MDU arithmetic helper used at issue time.
package mdu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    function automatic logic mdu_is_muldiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    // Returns {write_enable, hi, lo}. A zero divisor clears write_enable so
    // the architectural HI/LO keep their previous contents.
    function automatic logic [64:0] mdu_compute(input logic [3:0]  op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic        [64:0] res;
        // Signed divide is done at 64 bits so 0x80000000 / -1 yields
        // +2^31, whose low word is the required 0x80000000 with no trap.
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = '0;
        case (op)
            MDU_MULT:  res = {1'b1, 64'(sa * sb)};
            MDU_MULTU: res = {1'b1, 64'(ua * ub)};
            MDU_DIV: begin
                if (b != 32'd0) begin
                    res = {1'b1, 32'(sa % sb), 32'(sa / sb)};
                end
            end
            MDU_DIVU: begin
                if (b != 32'd0) begin
                    res = {1'b1, a % b, a / b};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. The arithmetic result is
// computed when the operation is issued and parked in a 64-bit register;
// a down-counter then models the multi-cycle latency before HI/LO update.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no operation in flight; accepts start, mthi, mtlo
// ST_RUN  | counting down latency; HI/LO written when count hits 1
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [63:0]       res_q,     res_d;
    logic              res_vld_q, res_vld_d;
    logic [31:0]       hi_q,      hi_d;
    logic [31:0]       lo_q,      lo_d;
    logic              busy_q,    busy_d;

    // Next-state: issue, latency countdown, HI/LO writeback and moves.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_vld_d = res_vld_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && mdu_is_muldiv(MDUOp)) begin
                    state_d                   = ST_RUN;
                    cnt_d                     = mdu_is_mult(MDUOp) ? CNT_W'(MULT_CYCLES)
                                                                   : CNT_W'(DIV_CYCLES);
                    {res_vld_d, res_d}        = mdu_compute(MDUOp, in_a, in_b);
                end else if (MDUOp == MDU_MTHI) begin
                    hi_d = in_a;
                end else if (MDUOp == MDU_MTLO) begin
                    lo_d = in_a;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (res_vld_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State and architectural registers; reset aborts any operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    // mfhi/mflo read the current registers; anything else reads zero.
    always_comb begin
        result = '0;
        if (MDUOp == MDU_MFHI) begin
            result = hi_q;
        end else if (MDUOp == MDU_MFLO) begin
            result = lo_q;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for the multiply/divide unit: directed vector table, reset and
// move corner cases, then random operations against a reference model.
module tb_mdu;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic        clk;
    logic        reset_n;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        int          disturb;   // 0 none, 1 re-issue start while busy, 2 mtlo while busy
    } vec_t;

    vec_t vecs[10];

    mdu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_a    (in_a),
        .in_b    (in_b),
        .MDUOp   (MDUOp),
        .start   (start),
        .busy    (busy),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, division via magnitudes.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, ma, mb, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT: begin
                p = sa * sb;
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            OP_MULTU: begin
                up = ua * ub;
                hi_m = up[63:32];
                lo_m = up[31:0];
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q = ma / mb;
                    r = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    lo_m = q[31:0];
                    hi_m = r[31:0];
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    up = ua / ub;
                    lo_m = up[31:0];
                    up = ua % ub;
                    hi_m = up[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Read HI and LO through mfhi/mflo within the current low clock phase.
    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        MDUOp = OP_MFHI;
        #1 hi = result;
        MDUOp = OP_MFLO;
        #1 lo = result;
        MDUOp = OP_NONE;
    endtask

    // Issue one mult/div and count busy cycles (bounded), optionally
    // disturbing the unit while it is busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int disturb, output int ncyc);
        @(negedge clk);
        MDUOp = op;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        #1 check("busy_on_start_cycle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        MDUOp = OP_NONE;
        in_a  = $urandom;
        in_b  = $urandom;
        ncyc  = 0;
        while (busy === 1'b1 && ncyc < 100) begin
            ncyc++;
            if (disturb == 1) begin
                start = 1'b1;
                MDUOp = OP_MULT;
                in_a  = $urandom;
                in_b  = $urandom;
            end else if (disturb == 2) begin
                start = 1'b0;
                MDUOp = OP_MTLO;
                in_a  = 32'hDEADBEEF;
            end
            @(negedge clk);
        end
        start = 1'b0;
        MDUOp = OP_NONE;
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        MDUOp = op;
        in_a  = a;
        @(negedge clk);
        MDUOp = OP_NONE;
        if (op == OP_MTHI) hi_m = a;
        if (op == OP_MTLO) lo_m = a;
    endtask

    initial begin
        logic [31:0] hi, lo;
        int          ncyc;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          exp_cyc;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  0};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5,  0};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1};
        vecs[3] = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10, 0};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 0};
        vecs[5] = '{OP_DIV,   32'd5,        32'd0,        32'h00000000, 32'h80000000, 10, 2};
        vecs[6] = '{OP_DIVU,  32'd7,        32'd0,        32'h00000000, 32'h80000000, 10, 1};
        vecs[7] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5,  0};
        vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  1};
        vecs[9] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 0};

        reset_n = 1'b0;
        MDUOp   = OP_NONE;
        start   = 1'b0;
        in_a    = '0;
        in_b    = '0;
        hi_m    = '0;
        lo_m    = '0;
        repeat (2) @(negedge clk);
        check("busy_in_reset", {31'd0, busy}, 32'd0);
        MDUOp = OP_MFHI;
        #1 check("result_in_reset", result, 32'd0);
        MDUOp = OP_NONE;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("busy_after_reset", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        check("hi_after_reset", hi, 32'd0);
        check("lo_after_reset", lo, 32'd0);

        // Moves to and from HI/LO.
        move(OP_MTHI, 32'h12345678);
        read_hilo(hi, lo);
        check("mthi_mfhi", hi, 32'h12345678);
        move(OP_MTLO, 32'h9ABCDEF0);
        read_hilo(hi, lo);
        check("mtlo_mflo", lo, 32'h9ABCDEF0);
        check("mtlo_keeps_hi", hi, 32'h12345678);
        #1 check("result_zero_for_none", result, 32'd0);

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].disturb, ncyc);
            check($sformatf("vec%0d_busy_cycles", i), ncyc, vecs[i].cycles);
            read_hilo(hi, lo);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // Start with a non-mult/div code is ignored.
        for (int c = 9; c < 16; c += 3) begin
            @(negedge clk);
            MDUOp = 4'(c);
            in_a  = 32'h55555555;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            MDUOp = OP_NONE;
            check($sformatf("bad_op%0d_no_busy", c), {31'd0, busy}, 32'd0);
        end
        read_hilo(hi, lo);
        check("bad_op_hi_kept", hi, 32'h00000001);
        check("bad_op_lo_kept", lo, 32'hFFFFFFFD);

        // Reset in the middle of a divide.
        move(OP_MTHI, 32'hA5A5A5A5);
        move(OP_MTLO, 32'h5A5A5A5A);
        @(negedge clk);
        MDUOp = OP_DIV;
        in_a  = 32'd100;
        in_b  = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        MDUOp = OP_NONE;
        ncyc  = 1;
        while (busy === 1'b1 && ncyc < 4) begin
            @(negedge clk);
            ncyc++;
        end
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1 check("busy_async_reset", {31'd0, busy}, 32'd0);
        MDUOp = OP_MFHI;
        #1 check("hi_async_reset", result, 32'd0);
        MDUOp = OP_MFLO;
        #1 check("lo_async_reset", result, 32'd0);
        MDUOp = OP_NONE;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        check("hi_after_abort", hi, 32'd0);
        check("lo_after_abort", lo, 32'd0);
        hi_m = '0;
        lo_m = '0;

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 5));
                3: a = 32'h80000000;
                default: ;
            endcase
            if ((i % 7) == 3) move(OP_MTHI, $urandom);
            if ((i % 5) == 2) move(OP_MTLO, $urandom);
            model(op, a, b);
            exp_cyc = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
            run_op(op, a, b, i % 3, ncyc);
            check($sformatf("rnd%0d_busy_cycles", i), ncyc, exp_cyc);
            read_hilo(hi, lo);
            check($sformatf("rnd%0d_hi", i), hi, hi_m);
            check($sformatf("rnd%0d_lo", i), lo, lo_m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_a, input, 32 bits: rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-006 SHALL have port in_b, input, 32 bits: rt operand (divisor / multiplier).
REQ-007 SHALL have port MDUOp, input, 4 bits: operation code; 0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=mfhi, 8=mflo; all other codes are treated as none.
REQ-008 SHALL have port start, input, 1 bit: issue strobe for mult/multu/div/divu, qualified in E stage.
REQ-009 SHALL have port busy, output, 1 bit: a multiply or divide is in progress.
REQ-010 SHALL have port result, output, 32 bits: HI for mfhi, LO for mflo, else 0.

Function
REQ-011 SHALL hold two 32-bit architectural registers, HI and LO.
REQ-012 SHALL use states IDLE and RUN; RUN holds a down-counter and latched op/operands.
REQ-013 In IDLE, start=1 with a mult/div op SHALL latch in_a, in_b, and the op, load the counter with the op's cycle count, and enter RUN on that edge.
REQ-014 busy SHALL be 1 on every cycle the FSM is in RUN, and 0 in IDLE (the start cycle itself shows busy=0).
REQ-015 In RUN, the counter SHALL decrement each cycle; on the edge where it reaches 1, HI/LO SHALL be written and the FSM SHALL return to IDLE.
REQ-016 Accordingly, busy SHALL be high for exactly MULT_CYCLES or DIV_CYCLES cycles, and the new HI/LO SHALL be visible on the first cycle busy=0.
REQ-017 start while busy=1 SHALL be ignored, and the in-flight operation SHALL be unaffected.
REQ-018 start with a non-mult/div MDUOp SHALL be ignored.
REQ-019 mult SHALL produce the signed 64-bit product, and multu the unsigned 64-bit product, with {HI,LO} = product.
REQ-020 div/divu SHALL produce LO = quotient, truncated toward zero, and HI = remainder, whose sign follows the dividend for div.
REQ-021 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 A divisor of zero SHALL leave HI and LO unchanged, while still costing DIV_CYCLES of busy.
REQ-023 mthi/mtlo SHALL write in_a into HI/LO at the next edge when busy=0; they SHALL be ignored while busy=1, because control stalls them.
REQ-024 mfhi/mflo SHALL drive result combinationally from the current HI/LO register value.
REQ-025 A start and an mthi/mtlo in the same cycle are impossible, because only one MDUOp is present per cycle; no arbitration is required.

Reset
REQ-026 reset_n=0 SHALL immediately, and asynchronously, force HI=0, LO=0, state=IDLE, counter=0, and busy=0.
REQ-027 A reset during RUN SHALL abort the operation; HI/LO SHALL remain 0 after release.
REQ-028 result SHALL read 0 during reset.

Structure
REQ-029 The MDUOp encodings and the default latencies SHALL reside in the shared CPU defines package, alongside the ALUOp encodings.
REQ-030 The arithmetic SHALL be computed once at start and held in a 64-bit pipeline register; the counter models latency only.
REQ-031 No sub-module is required; an optional mdu_div_core SHALL be the only permitted split.

Verification
REQ-032 mult: in_a=0xFFFFFFFE (-2), in_b=3, start -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu: in_a=0xFFFFFFFF, in_b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-034 div: in_a=-7, in_b=2 -> busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu of the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-035 div by 0, and div 0x80000000 / 0xFFFFFFFF: the first leaves the prior HI/LO unchanged; the second gives LO=0x80000000, HI=0.
REQ-036 start div, then assert reset_n=0 at busy cycle 4 -> busy=0 and HI=LO=0 immediately; start re-issued while busy -> ignored.
REQ-037 mthi 0x12345678 then mfhi -> result=0x12345678 on the next cycle; mtlo issued while busy -> LO unchanged.
